scpu_pipe_core: RTL and testbench



---
 rtl/scpu_pkg.sv | 56 +++++
 rtl/scpu_alu.sv | 40 ++++
 rtl/scpu_pipe_core.sv | 159 +++++++++++++++
 tb/tb_scpu_pipe_core.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scpu_pkg.sv
// Shared definitions for the scpu pipelined core: opcodes, run state, the NOP
// instruction word and instruction field extraction helpers.
package scpu_pkg;

  localparam int FIELD_W = 64;

  typedef enum logic [3:0] {
    OPC_NOP  = 4'h0,
    OPC_ADD  = 4'h1,
    OPC_SUB  = 4'h2,
    OPC_NAND = 4'h3,
    OPC_SHL  = 4'h4,
    OPC_SHR  = 4'h5,
    OPC_LI   = 4'h6,
    OPC_LD   = 4'h7,
    OPC_ST   = 4'h8,
    OPC_IN   = 4'h9,
    OPC_OUT  = 4'hA,
    OPC_BR   = 4'hB,
    OPC_BZ   = 4'hC,
    OPC_BN   = 4'hD,
    OPC_CALL = 4'hE,
    OPC_HALT = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } core_state_e;

  // All-zero word decodes as NOP for every width combination.
  localparam logic [FIELD_W-1:0] OP_NOP = '0;

  function automatic logic [FIELD_W-1:0] field_mask(input int w);
    return (w >= FIELD_W) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Instruction layout is {imm, op[3:0], ra, rb}, zero-extended to FIELD_W.
  function automatic opcode_e instr_op(input logic [FIELD_W-1:0] instr, input int ra_w);
    return opcode_e'(4'((instr >> (2 * ra_w)) & 64'hF));
  endfunction

  function automatic logic [FIELD_W-1:0] instr_ra(input logic [FIELD_W-1:0] instr, input int ra_w);
    return (instr >> ra_w) & field_mask(ra_w);
  endfunction

  function automatic logic [FIELD_W-1:0] instr_rb(input logic [FIELD_W-1:0] instr, input int ra_w);
    return instr & field_mask(ra_w);
  endfunction

  function automatic logic [FIELD_W-1:0] instr_imm(input logic [FIELD_W-1:0] instr,
                                                   input int ra_w, input int imm_w);
    return (instr >> (2 * ra_w + 4)) & field_mask(imm_w);
  endfunction

endpackage

// File: rtl/scpu_alu.sv
// Combinational ALU for the scpu core; also produces the LI immediate so that
// every register-writing result except IN and LD comes from one place.
module scpu_alu
  import scpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 8
) (
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              z_o,
  output logic              n_o,
  output logic              writes_flags_o
);

  // Widened so one slice covers both zero-extension and truncation of imm.
  logic [DATA_W+IMM_W-1:0] imm_ext;
  assign imm_ext = {{DATA_W{1'b0}}, imm_i};

  always_comb begin
    result_o       = a_i;
    writes_flags_o = 1'b0;
    case (op_i)
      OPC_ADD:  begin result_o = a_i + b_i;    writes_flags_o = 1'b1; end
      OPC_SUB:  begin result_o = a_i - b_i;    writes_flags_o = 1'b1; end
      OPC_NAND: begin result_o = ~(a_i & b_i); writes_flags_o = 1'b1; end
      OPC_SHL:  begin result_o = a_i << 1;     writes_flags_o = 1'b1; end
      OPC_SHR:  begin result_o = a_i >> 1;     writes_flags_o = 1'b1; end
      OPC_LI:   result_o = imm_ext[DATA_W-1:0];
      default:  result_o = a_i;
    endcase
  end

  assign z_o = (result_o == '0);
  assign n_o = result_o[DATA_W-1];

endmodule

// File: rtl/scpu_pipe_core.sv
// Three-stage (IF/EX/WB) accumulator-style CPU with instruction/data memory,
// register file, stalling external in/out handshakes and a HALT state.
module scpu_pipe_core
  import scpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2,
  parameter int IMM_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         ext_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         ext_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      prog_we,
  input  logic [IMM_W-1:0]          prog_addr,
  input  logic [IMM_W+4+2*RA_W-1:0] prog_data,
  output logic                      halted
);

  localparam int INSTR_W = IMM_W + 4 + 2 * RA_W;
  localparam int NREG    = 1 << RA_W;
  localparam int MEM_D   = 1 << IMM_W;

  logic [INSTR_W-1:0] imem_q [MEM_D];
  logic [DATA_W-1:0]  dmem_q [MEM_D];
  logic [DATA_W-1:0]  rf_q   [NREG];

  logic [IMM_W-1:0]   pc_q, pc_d, lr_q, target;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               z_q, n_q;
  core_state_e        state_q;
  logic               wb_valid_q, wb_from_mem_q;
  logic [RA_W-1:0]    wb_ra_q;
  logic [DATA_W-1:0]  wb_data_q, dm_rdata_q, wb_wdata;
  logic [DATA_W-1:0]  ext_out_q;
  logic               out_valid_q;

  opcode_e            op;
  logic [RA_W-1:0]    ra, rb;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  rd_a, rd_b, alu_res;
  logic               alu_z, alu_n, alu_wf;
  logic               is_halted, stall, fire, taken, wr_rf;

  assign op  = instr_op(FIELD_W'(ir_q), RA_W);
  assign ra  = RA_W'(instr_ra(FIELD_W'(ir_q), RA_W));
  assign rb  = RA_W'(instr_rb(FIELD_W'(ir_q), RA_W));
  assign imm = IMM_W'(instr_imm(FIELD_W'(ir_q), RA_W, IMM_W));

  // WB->EX forwarding; the LD result only exists in dm_rdata_q during WB.
  assign wb_wdata = wb_from_mem_q ? dm_rdata_q : wb_data_q;
  assign rd_a = (wb_valid_q && wb_ra_q == ra) ? wb_wdata : rf_q[ra];
  assign rd_b = (wb_valid_q && wb_ra_q == rb) ? wb_wdata : rf_q[rb];

  scpu_alu #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_alu (
    .op_i          (op),
    .a_i           (rd_a),
    .b_i           (rd_b),
    .imm_i         (imm),
    .result_o      (alu_res),
    .z_o           (alu_z),
    .n_o           (alu_n),
    .writes_flags_o(alu_wf)
  );

  // Handshakes: a word moves on any edge where valid && ready are both high.
  // in_ready depends only on ir; out_valid is registered and never waits on out_ready.
  assign is_halted = (state_q == ST_HALT);
  assign in_ready  = (op == OPC_IN) && !is_halted;
  assign stall     = !is_halted && (((op == OPC_IN) && !in_valid) ||
                                    ((op == OPC_OUT) && out_valid_q && !out_ready));
  assign fire      = !is_halted && !stall && (op != OPC_HALT);
  assign wr_rf     = fire && (((op >= OPC_ADD) && (op <= OPC_LD)) || (op == OPC_IN));

  always_comb begin
    taken  = 1'b0;
    target = imm;
    case (op)
      OPC_BR:   taken = 1'b1;
      OPC_BZ:   taken = z_q;
      OPC_BN:   taken = n_q;
      OPC_CALL: begin
        taken = 1'b1;
        if (ra[0]) target = lr_q;
      end
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (fire) begin
      if (taken) begin
        pc_d = target;
        ir_d = INSTR_W'(OP_NOP);
      end else begin
        pc_d = pc_q + IMM_W'(1);
        ir_d = imem_q[pc_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= '0;
      ir_q          <= INSTR_W'(OP_NOP);
      z_q           <= 1'b0;
      n_q           <= 1'b0;
      lr_q          <= '0;
      state_q       <= ST_RUN;
      wb_valid_q    <= 1'b0;
      wb_from_mem_q <= 1'b0;
      wb_ra_q       <= '0;
      wb_data_q     <= '0;
      ext_out_q     <= '0;
      out_valid_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      if (wb_valid_q) rf_q[wb_ra_q] <= wb_wdata;
      wb_valid_q    <= wr_rf;
      wb_ra_q       <= ra;
      wb_from_mem_q <= (op == OPC_LD);
      wb_data_q     <= (op == OPC_IN) ? ext_in : alu_res;
      if (fire && alu_wf) begin
        z_q <= alu_z;
        n_q <= alu_n;
      end
      // pc_q already points one past the instruction in EX.
      if (fire && op == OPC_CALL && !ra[0]) lr_q <= pc_q;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (fire && op == OPC_OUT) begin
        ext_out_q   <= rd_a;
        out_valid_q <= 1'b1;
      end
      if (!is_halted && op == OPC_HALT) state_q <= ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fire && op == OPC_ST) dmem_q[imm] <= rd_a;
    if (fire && op == OPC_LD) dm_rdata_q <= dmem_q[imm];
  end

  always_ff @(posedge clk) begin
    if (prog_we) imem_q[prog_addr] <= prog_data;
  end

  assign ext_out   = ext_out_q;
  assign out_valid = out_valid_q;
  assign halted    = is_halted;

endmodule

// File: tb/tb_scpu_pipe_core.sv
// Directed bench for scpu_pipe_core: an 8-bit instance and a 16-bit/8-register
// instance, programs loaded through the prog port, outputs scored by cycle.
module tb_scpu_pipe_core;

  localparam logic [3:0] O_NOP = 4'h0, O_ADD = 4'h1, O_SUB = 4'h2, O_NAND = 4'h3,
                         O_SHL = 4'h4, O_SHR = 4'h5, O_LI = 4'h6, O_LD = 4'h7,
                         O_ST = 4'h8, O_IN = 4'h9, O_OUT = 4'hA, O_BR = 4'hB,
                         O_BZ = 4'hC, O_BN = 4'hD, O_CALL = 4'hE, O_HALT = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, prog_we = 1'b0;
  logic        in_ready, out_valid, halted;
  logic [7:0]  ext_in = '0, ext_out, prog_addr = '0;
  logic [15:0] prog_data = '0;

  logic        rst_w = 1'b1, in_valid_w = 1'b0, out_ready_w = 1'b0, prog_we_w = 1'b0;
  logic        in_ready_w, out_valid_w, halted_w;
  logic [15:0] ext_in_w = '0, ext_out_w;
  logic [7:0]  prog_addr_w = '0;
  logic [17:0] prog_data_w = '0;

  scpu_pipe_core #(.DATA_W(8), .RA_W(2), .IMM_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .ext_in(ext_in), .in_valid(in_valid), .in_ready(in_ready),
    .ext_out(ext_out), .out_valid(out_valid), .out_ready(out_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .halted(halted)
  );

  scpu_pipe_core #(.DATA_W(16), .RA_W(3), .IMM_W(8)) u_dut16 (
    .clk(clk), .rst(rst_w), .ext_in(ext_in_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .ext_out(ext_out_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .prog_we(prog_we_w), .prog_addr(prog_addr_w), .prog_data(prog_data_w), .halted(halted_w)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [15:0] prog8 [256];
  logic [17:0] prog16 [256];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int exp_cyc_q[$];
  int got_cyc_q[$];

  // Every accepted output word with the cycle (edges since reset release) it appeared in.
  always @(negedge clk) begin
    if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
      got_q.push_back({8'h00, ext_out});
      got_cyc_q.push_back(cyc);
    end
    if (mon_en && out_valid_w === 1'b1 && out_ready_w === 1'b1) begin
      got_q.push_back(ext_out_w);
      got_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [15:0] enc8(input logic [3:0] op, input logic [1:0] ra,
                                       input logic [1:0] rb, input logic [7:0] imm);
    return {imm, op, ra, rb};
  endfunction

  function automatic logic [17:0] enc16(input logic [3:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [7:0] imm);
    return {imm, op, ra, rb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_progs();
    for (int a = 0; a < 256; a++) begin
      prog8[a]  = enc8(O_HALT, 2'd0, 2'd0, 8'h00);
      prog16[a] = enc16(O_HALT, 3'd0, 3'd0, 8'h00);
    end
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic load_prog(input bit wide);
    mon_en = 1'b0;
    rst = 1'b1;
    rst_w = 1'b1;
    for (int a = 0; a < 256; a++) begin
      if (wide) begin
        prog_we_w = 1'b1; prog_addr_w = 8'(a); prog_data_w = prog16[a];
      end else begin
        prog_we = 1'b1; prog_addr = 8'(a); prog_data = prog8[a];
      end
      @(posedge clk);
      #1;
    end
    prog_we = 1'b0;
    prog_we_w = 1'b0;
    @(posedge clk);
    #1;
    got_q.delete();
    got_cyc_q.delete();
    cyc = 0;
    mon_en = 1'b1;
    if (wide) rst_w = 1'b0;
    else rst = 1'b0;
  endtask

  task automatic run_prog(input int max_cyc, input bit wide, output int hcyc);
    hcyc = -1;
    while (cyc < max_cyc && hcyc < 0) begin
      tick();
      if ((wide ? halted_w : halted) === 1'b1) hcyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_w = 1'b1;
    repeat (2) tick();
    checks++;
    if (ext_out !== 8'h00 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out8 got=%h/%b exp=00/0", ext_out, out_valid);
    end
    checks++;
    if (halted !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ctl8 got=halted %b in_ready %b exp=0/0", halted, in_ready);
    end
    checks++;
    if (ext_out_w !== 16'h0000 || out_valid_w !== 1'b0 || halted_w !== 1'b0 || in_ready_w !== 1'b0) begin
      failures++; $display("FAIL reset_16 got=%h/%b/%b/%b exp=0000/0/0/0",
                           ext_out_w, out_valid_w, halted_w, in_ready_w);
    end
  endtask

  task automatic test_basic();
    int h;
    clear_progs();
    prog8[0] = enc8(O_LI,  2'd0, 2'd0, 8'h05);
    prog8[1] = enc8(O_LI,  2'd1, 2'd0, 8'h03);
    prog8[2] = enc8(O_ADD, 2'd0, 2'd1, 8'h00);
    prog8[3] = enc8(O_OUT, 2'd0, 2'd0, 8'h00);
    prog8[4] = enc8(O_HALT, 2'd0, 2'd0, 8'h00);
    exp_q.push_back(16'h0008); exp_cyc_q.push_back(5);
    out_ready = 1'b1;
    load_prog(1'b0);
    run_prog(40, 1'b0, h);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++; $display("FAIL basic_out%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (h !== 6) begin failures++; $display("FAIL basic_halt_cycle got=%0d exp=6", h); end
    repeat (3) tick();
    checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_halt_hold got=halted %b out_valid %b exp=1/0", halted, out_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL basic_halt_clear got=%b exp=0", halted); end
  endtask

  task automatic test_forward_chain();
    int h;
    clear_progs();
    prog8[0] = enc8(O_LI,  2'd0, 2'd0, 8'h01);
    prog8[1] = enc8(O_LI,  2'd1, 2'd0, 8'h01);
    for (int a = 2; a < 5; a++) prog8[a] = enc8(O_ADD, 2'd0, 2'd1, 8'h00);
    prog8[5] = enc8(O_OUT, 2'd0, 2'd0, 8'h00);
    exp_q.push_back(16'h0004); exp_cyc_q.push_back(7);
    out_ready = 1'b1;
    load_prog(1'b0);
    run_prog(40, 1'b0, h);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL chain_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++; $display("FAIL chain_out%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (h !== 8) begin failures++; $display("FAIL chain_halt_cycle got=%0d exp=8", h); end
  endtask

  task automatic test_load_use();
    int h;
    clear_progs();
    prog8[0] = enc8(O_LI,  2'd0, 2'd0, 8'hA5);
    prog8[1] = enc8(O_ST,  2'd0, 2'd0, 8'h10);
    prog8[2] = enc8(O_LD,  2'd2, 2'd0, 8'h10);
    prog8[3] = enc8(O_OUT, 2'd2, 2'd0, 8'h00);
    exp_q.push_back(16'h00A5); exp_cyc_q.push_back(5);
    out_ready = 1'b1;
    load_prog(1'b0);
    run_prog(40, 1'b0, h);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL ldst_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++; $display("FAIL ldst_out%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (h !== 6) begin failures++; $display("FAIL ldst_halt_cycle got=%0d exp=6", h); end
  endtask

  task automatic test_branch_call();
    int h;
    clear_progs();
    prog8[0]    = enc8(O_LI,   2'd3, 2'd0, 8'h07);
    prog8[1]    = enc8(O_LI,   2'd0, 2'd0, 8'h09);
    prog8[2]    = enc8(O_SUB,  2'd0, 2'd0, 8'h00);
    prog8[3]    = enc8(O_BZ,   2'd0, 2'd0, 8'h20);
    prog8[4]    = enc8(O_LI,   2'd3, 2'd0, 8'h01);
    prog8[8'h20] = enc8(O_OUT,  2'd3, 2'd0, 8'h00);
    prog8[8'h21] = enc8(O_CALL, 2'd0, 2'd0, 8'h40);
    prog8[8'h22] = enc8(O_OUT,  2'd1, 2'd0, 8'h00);
    prog8[8'h40] = enc8(O_LI,   2'd1, 2'd0, 8'h77);
    prog8[8'h41] = enc8(O_CALL, 2'd1, 2'd0, 8'h00);
    exp_q.push_back(16'h0007); exp_cyc_q.push_back(7);
    exp_q.push_back(16'h0077); exp_cyc_q.push_back(13);
    out_ready = 1'b1;
    load_prog(1'b0);
    run_prog(60, 1'b0, h);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL branch_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++; $display("FAIL branch_out%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (h !== 14) begin failures++; $display("FAIL branch_halt_cycle got=%0d exp=14", h); end
  endtask

  task automatic test_alu_flags();
    int h;
    clear_progs();
    prog8[0]  = enc8(O_LI,   2'd0, 2'd0, 8'hF0);
    prog8[1]  = enc8(O_LI,   2'd1, 2'd0, 8'h3C);
    prog8[2]  = enc8(O_NAND, 2'd0, 2'd1, 8'h00);
    prog8[3]  = enc8(O_OUT,  2'd0, 2'd0, 8'h00);
    prog8[4]  = enc8(O_SHR,  2'd0, 2'd0, 8'h00);
    prog8[5]  = enc8(O_OUT,  2'd0, 2'd0, 8'h00);
    prog8[6]  = enc8(O_SUB,  2'd0, 2'd1, 8'h00);
    prog8[7]  = enc8(O_OUT,  2'd0, 2'd0, 8'h00);
    prog8[8]  = enc8(O_LI,   2'd2, 2'd0, 8'h01);
    prog8[9]  = enc8(O_SUB,  2'd2, 2'd1, 8'h00);
    prog8[10] = enc8(O_BN,   2'd0, 2'd0, 8'h50);
    prog8[11] = enc8(O_OUT,  2'd0, 2'd0, 8'h00);
    prog8[8'h50] = enc8(O_OUT, 2'd2, 2'd0, 8'h00);
    exp_q.push_back(16'h00CF); exp_cyc_q.push_back(5);
    exp_q.push_back(16'h0067); exp_cyc_q.push_back(7);
    exp_q.push_back(16'h002B); exp_cyc_q.push_back(9);
    exp_q.push_back(16'h00C5); exp_cyc_q.push_back(14);
    out_ready = 1'b1;
    load_prog(1'b0);
    run_prog(60, 1'b0, h);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL alu_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++; $display("FAIL alu_out%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (h !== 15) begin failures++; $display("FAIL alu_halt_cycle got=%0d exp=15", h); end
  endtask

  task automatic test_in_stall();
    int h;
    clear_progs();
    prog8[0] = enc8(O_IN,  2'd0, 2'd0, 8'h00);
    prog8[1] = enc8(O_OUT, 2'd0, 2'd0, 8'h00);
    exp_q.push_back(16'h003C); exp_cyc_q.push_back(8);
    out_ready = 1'b1; in_valid = 1'b0; ext_in = 8'h00;
    load_prog(1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL in_ready_wait cyc=%0d got=%b exp=1", cyc, in_ready); end
    end
    in_valid = 1'b1; ext_in = 8'h3C;
    tick();
    in_valid = 1'b0; ext_in = 8'h00;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL in_ready_after got=%b exp=0", in_ready); end
    run_prog(40, 1'b0, h);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL in_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++; $display("FAIL in_out%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (h !== 9) begin failures++; $display("FAIL in_halt_cycle got=%0d exp=9", h); end
  endtask

  task automatic test_out_stall();
    int h;
    clear_progs();
    prog8[0] = enc8(O_LI,  2'd0, 2'd0, 8'h11);
    prog8[1] = enc8(O_OUT, 2'd0, 2'd0, 8'h00);
    prog8[2] = enc8(O_LI,  2'd0, 2'd0, 8'h22);
    prog8[3] = enc8(O_OUT, 2'd0, 2'd0, 8'h00);
    exp_q.push_back(16'h0011); exp_cyc_q.push_back(8);
    exp_q.push_back(16'h0022); exp_cyc_q.push_back(9);
    out_ready = 1'b0;
    load_prog(1'b0);
    repeat (2) tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (ext_out !== 8'h11 || out_valid !== 1'b1) begin
        failures++; $display("FAIL out_hold cyc=%0d got=%h/%b exp=11/1", cyc, ext_out, out_valid);
      end
    end
    out_ready = 1'b1;
    run_prog(40, 1'b0, h);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL outst_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++; $display("FAIL outst_out%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (h !== 10) begin failures++; $display("FAIL outst_halt_cycle got=%0d exp=10", h); end
  endtask

  task automatic test_wide();
    int h;
    clear_progs();
    prog16[0] = enc16(O_LI,  3'd7, 3'd0, 8'hFF);
    prog16[1] = enc16(O_SHL, 3'd7, 3'd0, 8'h00);
    prog16[2] = enc16(O_BN,  3'd0, 3'd0, 8'h30);
    prog16[3] = enc16(O_OUT, 3'd7, 3'd0, 8'h00);
    exp_q.push_back(16'h01FE); exp_cyc_q.push_back(5);
    out_ready_w = 1'b1;
    load_prog(1'b1);
    run_prog(40, 1'b1, h);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL wide_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++; $display("FAIL wide_out%0d got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (h !== 6) begin failures++; $display("FAIL wide_halt_cycle got=%0d exp=6", h); end
    rst_w = 1'b1;
  endtask

  task automatic test_mid_reset();
    clear_progs();
    prog8[0] = enc8(O_LI,  2'd0, 2'd0, 8'h5A);
    prog8[1] = enc8(O_OUT, 2'd0, 2'd0, 8'h00);
    prog8[2] = enc8(O_IN,  2'd1, 2'd0, 8'h00);
    out_ready = 1'b0; in_valid = 1'b0;
    load_prog(1'b0);
    repeat (4) tick();
    checks++;
    if (ext_out !== 8'h5A || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_before got=%h/%b/%b exp=5a/1/1", ext_out, out_valid, in_ready);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (ext_out !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL midrst_after got=%h/%b/%b/%b exp=00/0/0/0", ext_out, out_valid, in_ready, halted);
    end
    rst = 1'b0;
    cyc = 0;
    repeat (3) tick();
    checks++;
    if (ext_out !== 8'h5A || out_valid !== 1'b1) begin
      failures++; $display("FAIL midrst_restart got=%h/%b exp=5a/1", ext_out, out_valid);
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward_chain();
    test_load_use();
    test_branch_call();
    test_alu_flags();
    test_in_stall();
    test_out_stall();
    test_wide();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
